// File: rtl/ofdm_rx_pkg.sv
// Shared constants and FSM state type for the OFDM receive chain back end.
package ofdm_rx_pkg;

  localparam int ACTIVE_SUBCARR  = 28;
  localparam int SYMBOL_NUM      = 8;
  localparam int N_SAMPLES       = ACTIVE_SUBCARR * SYMBOL_NUM;
  localparam int SYMS_PER_BYTE   = 4;
  localparam int BYTES_PER_BURST = N_SAMPLES / SYMS_PER_BYTE;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    RELEASE,
    WAIT_CLR
  } rx_state_t;

endpackage

// File: rtl/sym_fifo.sv
// Small show-ahead synchronous FIFO holding demapped QPSK symbols.
module sym_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr;
  logic             rd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= bump(wr_ptr);
      if (rd) rd_ptr <= bump(rd_ptr);
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The read credit scheme upstream must make these impossible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      no_overflow:  assert (!(push && full));
      no_underflow: assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/eq_qpsk_demapper.sv
// Sweeps a full equalizer burst, hard-demaps each sample to QPSK bits and
// streams them out four subcarriers per byte, then releases the equalizer.
module eq_qpsk_demapper
  import ofdm_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                eq_buff_full,
  input  logic [2*DATA_W-1:0] eq_dout,
  output logic [7:0]          eq_read_ptr,
  output logic                eq_release,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                byte_last,
  output logic                busy
);

  localparam int         CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int         IF_W      = $clog2(RD_LATENCY + 1);
  localparam logic [7:0] LAST_ADDR = 8'(N_SAMPLES - 1);
  localparam logic [5:0] LAST_BYTE = 6'(BYTES_PER_BURST - 1);

  rx_state_t             state;
  logic [7:0]            rd_cnt;
  logic [RD_LATENCY-1:0] rd_vld_p;
  logic [IF_W-1:0]       in_flight;
  logic [7:0]            credit_used;
  logic                  issue;
  logic                  start;
  logic                  drained;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [1:0]            sym_p0;
  logic [1:0]            fifo_dout;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic [7:0]            pk_data;
  logic [2:0]            pk_cnt;
  logic [5:0]            byte_cnt;
  logic                  load;

  // Sign-bit hard decision; zero lands on the positive side.
  function automatic logic [1:0] demap(input logic [2*DATA_W-1:0] s);
    logic signed [DATA_W-1:0] im;
    logic signed [DATA_W-1:0] re;
    im = s[2*DATA_W-1:DATA_W];
    re = s[DATA_W-1:0];
    return {im < 0, re < 0};
  endfunction

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + IF_W'(rd_vld_p[i]);
    credit_used = 8'(fifo_count) + 8'(in_flight);
  end

  // A read is only issued when a FIFO slot is reserved for its data.
  assign issue   = (state == READ) && (credit_used < 8'(FIFO_DEPTH)) && !fifo_full;
  assign start   = (state == IDLE) && eq_buff_full;
  assign drained = (in_flight == '0) && fifo_empty && (pk_cnt == 3'd0) && !byte_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      eq_read_ptr <= '0;
      eq_release  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      eq_release <= 1'b0;
      case (state)
        IDLE: begin
          if (eq_buff_full) begin
            state  <= READ;
            rd_cnt <= '0;
            busy   <= 1'b1;
          end
        end
        READ: begin
          if (issue) begin
            eq_read_ptr <= rd_cnt;
            rd_cnt      <= rd_cnt + 8'd1;
            if (rd_cnt == LAST_ADDR) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            state      <= RELEASE;
            eq_release <= 1'b1;
          end
        end
        RELEASE: state <= WAIT_CLR;
        WAIT_CLR: begin
          if (!eq_buff_full) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p0: read-tag pipe matching the equalizer buffer latency
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p <= '0;
    end else begin
      rd_vld_p[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) rd_vld_p[i] <= rd_vld_p[i-1];
    end
  end

  assign fifo_push = rd_vld_p[RD_LATENCY-1];
  assign sym_p0    = demap(eq_dout);

  sym_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sym_p0),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // p1: packer collects four symbols; p2: output register with handshake
  assign load     = (pk_cnt == 3'd4) && (!byte_valid || byte_ready);
  assign fifo_pop = !fifo_empty && ((pk_cnt != 3'd4) || load);

  always_ff @(posedge clk) begin
    if (rst) begin
      pk_data    <= '0;
      pk_cnt     <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      if (load) begin
        byte_out   <= pk_data;
        byte_valid <= 1'b1;
        byte_last  <= (byte_cnt == LAST_BYTE);
        byte_cnt   <= byte_cnt + 6'd1;
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
        byte_last  <= 1'b0;
      end
      if (start) byte_cnt <= '0;

      if (load) begin
        pk_cnt  <= fifo_pop ? 3'd1 : 3'd0;
        pk_data <= fifo_pop ? {6'b0, fifo_dout} : 8'h00;
      end else if (fifo_pop) begin
        pk_data[{pk_cnt[1:0], 1'b0} +: 2] <= fifo_dout;
        pk_cnt <= pk_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_eq_qpsk_demapper.sv
// Bench for eq_qpsk_demapper with a behavioural equalizer buffer model.
module tb_eq_qpsk_demapper;

  localparam int NS  = 224;
  localparam int NB  = 56;
  localparam int FD  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eq_buff_full = 1'b0;
  logic [15:0] eq_dout;
  logic [7:0]  eq_read_ptr;
  logic        eq_release;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        byte_last;
  logic        busy;

  logic [15:0] mem [256];
  logic [15:0] rd1;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_b[$];
  bit          got_l[$];

  int total = 0;
  int bad   = 0;
  int rel_cnt, rel_bytes, exp_next, ord_err, maxc;
  bit hold_prev = 0;
  logic [7:0] prev_b;
  logic       prev_l;

  always #5 clk = ~clk;

  eq_qpsk_demapper u_dut (
    .clk          (clk),
    .rst          (rst),
    .eq_buff_full (eq_buff_full),
    .eq_dout      (eq_dout),
    .eq_read_ptr  (eq_read_ptr),
    .eq_release   (eq_release),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_last    (byte_last),
    .busy         (busy)
  );

  // Equalizer output buffer: BRAM read stage plus registered output.
  always @(posedge clk) begin
    rd1     <= mem[eq_read_ptr];
    eq_dout <= rd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: each byte = sum of 4 sign-decided symbols weighted by 4^k.
  function automatic void build_exp();
    exp_q.delete();
    for (int b = 0; b < NB; b++) begin
      int v = 0;
      for (int k = 0; k < 4; k++) begin
        logic [15:0] s = mem[4*b+k];
        int im = int'($signed(s[15:8]));
        int re = int'($signed(s[7:0]));
        int sym = (im < 0 ? 2 : 0) + (re < 0 ? 1 : 0);
        v += sym * (4 ** k);
      end
      exp_q.push_back(8'(v));
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        chk("stable_valid", byte_valid, 1);
        chk("stable_byte", byte_out, prev_b);
        chk("stable_last", byte_last, prev_l);
      end
      hold_prev = byte_valid && !byte_ready;
      prev_b    = byte_out;
      prev_l    = byte_last;
      if (byte_valid && byte_ready) begin
        got_b.push_back(byte_out);
        got_l.push_back(byte_last);
      end
      if (eq_release) begin
        rel_cnt++;
        rel_bytes = got_b.size();
      end
      if (int'(eq_read_ptr) == exp_next) exp_next++;
      else if (exp_next > 0 && int'(eq_read_ptr) != exp_next - 1) ord_err++;
      if (int'(u_dut.fifo_count) > maxc) maxc = int'(u_dut.fifo_count);
    end else begin
      hold_prev = 0;
    end
  end

  // mode 0: ready high, 1: random ready, 2: 20-cycle ready stall at byte 20
  task automatic run_burst(input int mode, input bit early_drop, input string tag);
    int stall_cyc = 0;
    bit stall_done = 0;
    logic [7:0] ptr_a = 8'h00;
    int nlast = 0;
    got_b.delete();
    got_l.delete();
    rel_cnt = 0; rel_bytes = -1; exp_next = 0; ord_err = 0; maxc = 0;
    eq_buff_full = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      if (rel_cnt > 0) break;
      if (early_drop && got_b.size() >= 30) eq_buff_full = 1'b0;
      case (mode)
        1: byte_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!stall_done && got_b.size() >= 20) begin
            byte_ready = 1'b0;
            stall_cyc++;
            if (stall_cyc == 12) ptr_a = eq_read_ptr;
            if (stall_cyc == 20) begin
              chk({tag, ":stall_ptr"}, eq_read_ptr, ptr_a);
              stall_done = 1;
            end
          end else begin
            byte_ready = 1'b1;
          end
        end
        default: byte_ready = 1'b1;
      endcase
    end
    chk({tag, ":release_seen"}, rel_cnt > 0, 1);
    byte_ready = 1'b1;
    if (!early_drop) begin
      repeat (6) @(posedge clk);
      #1;
      chk({tag, ":hold_busy"}, busy, 1);
      chk({tag, ":hold_ptr"}, eq_read_ptr, NS - 1);
    end
    eq_buff_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ":idle_busy"}, busy, 0);
    chk({tag, ":rel_cnt"}, rel_cnt, 1);
    chk({tag, ":rel_after_bytes"}, rel_bytes, NB);
    chk({tag, ":nbytes"}, got_b.size(), NB);
    for (int b = 0; b < NB && b < got_b.size(); b++)
      chk($sformatf("%s:byte%0d", tag, b), got_b[b], exp_q[b]);
    foreach (got_l[i]) if (got_l[i]) nlast++;
    chk({tag, ":last_cnt"}, nlast, 1);
    if (got_l.size() >= NB) chk({tag, ":last_pos"}, got_l[NB-1], 1);
    chk({tag, ":rd_order"}, ord_err, 0);
    chk({tag, ":rd_count"}, exp_next, NS);
    chk({tag, ":fifo_max"}, maxc <= FD, 1);
  endtask

  typedef struct {
    logic [15:0] s0, s1, s2, s3;
    logic [7:0]  exp;
  } vec_t;

  initial begin
    vec_t tbl [5];
    tbl[0] = '{16'h0505, 16'h0505, 16'h0505, 16'h0505, 8'h00};
    tbl[1] = '{16'h05F8, 16'hF805, 16'h05F8, 16'hF805, 8'h99};
    tbl[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00};
    tbl[3] = '{16'h8080, 16'h8080, 16'h8080, 16'h8080, 8'hFF};
    tbl[4] = '{16'h7F80, 16'h807F, 16'h0000, 16'hFF01, 8'h89};

    for (int j = 0; j < 256; j++) mem[j] = 16'h0000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:ptr", eq_read_ptr, 0);
    chk("rst:release", eq_release, 0);
    chk("rst:byte_out", byte_out, 0);
    chk("rst:valid", byte_valid, 0);
    chk("rst:last", byte_last, 0);
    chk("rst:busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < NS; j++) begin
        case (j % 4)
          0: mem[j] = tbl[i].s0;
          1: mem[j] = tbl[i].s1;
          2: mem[j] = tbl[i].s2;
          default: mem[j] = tbl[i].s3;
        endcase
      end
      exp_q.delete();
      for (int b = 0; b < NB; b++) exp_q.push_back(tbl[i].exp);
      run_burst(0, 0, $sformatf("vec%0d", i));
    end

    for (int j = 0; j < NS; j++) mem[j] = {8'(-(j % 2)), 8'd1};
    build_exp();
    run_burst(2, 0, "stall");

    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < NS; j++) mem[j] = 16'($urandom);
      build_exp();
      run_burst(1, r == 1, $sformatf("rand%0d", r));
    end

    for (int j = 0; j < NS; j++) mem[j] = 16'($urandom);
    got_b.delete();
    got_l.delete();
    rel_cnt = 0;
    byte_ready = 1'b1;
    eq_buff_full = 1'b1;
    for (int cyc = 0; cyc < 2000 && got_b.size() < 20; cyc++) begin
      @(posedge clk); #1;
    end
    chk("mid_rst:reached", got_b.size() >= 20, 1);
    rst = 1'b1;
    eq_buff_full = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst:ptr", eq_read_ptr, 0);
    chk("mid_rst:release", eq_release, 0);
    chk("mid_rst:byte_out", byte_out, 0);
    chk("mid_rst:valid", byte_valid, 0);
    chk("mid_rst:last", byte_last, 0);
    chk("mid_rst:busy", busy, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst:no_release", rel_cnt, 0);
    chk("mid_rst:still_idle", busy, 0);
    chk("mid_rst:no_bytes", byte_valid, 0);

    for (int j = 0; j < NS; j++) mem[j] = 16'($urandom);
    build_exp();
    run_burst(0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
